// File: rtl/render_menu_n.sv
// Menu renderer with mouse/keyboard selection.
// Three-stage pixel pipeline advanced by pix_en: S1 finds the item and label
// under the pixel, S2 issues the glyph ROM address, S3 picks the colour once
// the synchronous ROM has answered. A four-state FSM on every clk tracks the
// focused item, mouse presses and the confirmed-selection handshake.
module render_menu_n #(
   parameter int unsigned N_ITEMS = 3,
   parameter int unsigned X0      = 160,
   parameter int unsigned Y0      = 80,
   parameter int unsigned BTN_W   = 320,
   parameter int unsigned BTN_H   = 60,
   parameter int unsigned PITCH   = 120,
   parameter int unsigned LBL_W   = 60,
   parameter int unsigned LBL_H   = 20,
   parameter int unsigned LBL_S   = 2,
   parameter int unsigned LBL_DX  = 80,
   parameter int unsigned LBL_DY  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        in_active,
   input  logic [9:0]  mouse_x,
   input  logic [9:0]  mouse_y,
   input  logic        mouse_btn,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_enter,
   output logic [13:0] rom_addr,
   input  logic        rom_data,
   output logic [11:0] pixel,
   output logic        out_active,
   output logic        sel_valid,
   output logic [2:0]  sel_idx,
   input  logic        sel_ready,
   output logic [2:0]  focus_idx
);

   // Geometry constants, all kept at 32 bits so comparisons never truncate.
   localparam logic [31:0] BTN_X1    = X0 + BTN_W;
   localparam logic [31:0] PITCH32   = PITCH;
   localparam logic [31:0] LBL_X0    = X0 + LBL_DX;
   localparam logic [31:0] LBL_X1    = X0 + LBL_DX + LBL_W * LBL_S;
   localparam logic [31:0] LBL_Y0    = Y0 + LBL_DY;
   localparam logic [31:0] LBL_SPANY = LBL_H * LBL_S;
   localparam logic [31:0] LBL_S32   = LBL_S;
   localparam logic [31:0] LBL_W32   = LBL_W;
   localparam logic [31:0] LBL_AREA  = LBL_W * LBL_H;
   localparam logic [31:0] LAST32    = N_ITEMS - 1;

   localparam logic [9:0]  LBL_X0_10 = LBL_X0[9:0];
   localparam logic [9:0]  LBL_S10   = LBL_S32[9:0];
   localparam logic [13:0] LBL_W14   = LBL_W32[13:0];
   localparam logic [13:0] LBL_A14   = LBL_AREA[13:0];
   localparam logic [2:0]  LAST_IDX  = LAST32[2:0];

   localparam logic [11:0] COL_BLACK = 12'h000;
   localparam logic [11:0] COL_TEXT  = 12'hfff;
   localparam logic [11:0] COL_PRESS = 12'h743;
   localparam logic [11:0] COL_FOCUS = 12'h632;
   localparam logic [11:0] COL_ITEM  = 12'h521;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOVER = 2'd1,
      ST_PRESS = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // Returns {hit, index} of the button containing (x, y); half-open bounds.
   function automatic logic [3:0] item_lookup(input logic [9:0] x, input logic [9:0] y);
      logic [31:0] xx;
      logic [31:0] yy;
      logic [31:0] top;
      logic [3:0]  res;
      logic        hit;
      xx  = {22'd0, x};
      yy  = {22'd0, y};
      res = 4'd0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         top = Y0 + i * PITCH;
         hit = (xx >= X0) && (xx < BTN_X1) && (yy >= top) && (yy < top + BTN_H);
         res = (hit && !res[3]) ? {1'b1, i[2:0]} : res;
      end
      return res;
   endfunction

   // ---------------- pipeline ----------------
   logic [3:0]  w_item;
   logic        w_item_hit;
   logic [2:0]  w_item_idx;
   logic [31:0] w_ltop;
   logic        w_lbl_hit;
   logic [9:0]  w_dx;
   logic [9:0]  w_dy;
   logic [13:0] w_addr;
   logic [11:0] w_pix_nxt;

   logic        r_s1_act;
   logic        r_s1_item;
   logic        r_s1_lbl;
   logic [2:0]  r_s1_idx;
   logic [9:0]  r_s1_row;
   logic [9:0]  r_s1_col;
   logic        r_s2_act;
   logic        r_s2_item;
   logic        r_s2_lbl;
   logic [2:0]  r_s2_idx;
   logic [13:0] r_rom_addr;
   logic [11:0] r_pixel;
   logic        r_out_active;

   // ---------------- selection FSM ----------------
   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_focus;
   logic [2:0]  w_focus_nxt;
   logic [2:0]  r_pressed;
   logic [2:0]  w_pressed_nxt;
   logic [2:0]  r_sel_idx;
   logic [2:0]  w_sel_idx_nxt;
   logic        r_sel_valid;
   logic        r_btn_q;
   logic        r_hov_prev_v;
   logic [2:0]  r_hov_prev_idx;
   logic [3:0]  w_hov;
   logic        w_hov_v;
   logic [2:0]  w_hov_idx;
   logic        w_hov_new;
   logic        w_btn_rise;
   logic        w_btn_fall;
   logic [2:0]  w_focus_inc;
   logic [2:0]  w_focus_dec;

   // S1 combinational: item/label hit and label offsets (only after a hit).
   always_comb begin
      w_item     = item_lookup(h_cnt, v_cnt);
      w_item_hit = w_item[3];
      w_item_idx = w_item[2:0];
      w_ltop     = LBL_Y0 + ({29'd0, w_item_idx} * PITCH32);
      w_lbl_hit  = w_item_hit
                   && ({22'd0, h_cnt} >= LBL_X0) && ({22'd0, h_cnt} < LBL_X1)
                   && ({22'd0, v_cnt} >= w_ltop) && ({22'd0, v_cnt} < w_ltop + LBL_SPANY);
      if (w_lbl_hit) begin
         w_dx = h_cnt - LBL_X0_10;
         w_dy = v_cnt - w_ltop[9:0];
      end else begin
         w_dx = 10'd0;
         w_dy = 10'd0;
      end
   end

   // S1 registers: flags, item index and glyph row/column.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_act  <= 1'b0;
         r_s1_item <= 1'b0;
         r_s1_lbl  <= 1'b0;
         r_s1_idx  <= 3'd0;
         r_s1_row  <= 10'd0;
         r_s1_col  <= 10'd0;
      end else if (pix_en) begin
         r_s1_act  <= in_active;
         r_s1_item <= w_item_hit;
         r_s1_lbl  <= w_lbl_hit;
         r_s1_idx  <= w_item_idx;
         r_s1_row  <= w_dy / LBL_S10;
         r_s1_col  <= w_dx / LBL_S10;
      end
   end

   // S2 combinational: glyph address of the label pixel.
   always_comb begin
      w_addr = ({11'd0, r_s1_idx} * LBL_A14) + ({4'd0, r_s1_row} * LBL_W14) + {4'd0, r_s1_col};
   end

   // S2 registers: ROM address (held between strobes) and forwarded flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rom_addr <= 14'd0;
         r_s2_act   <= 1'b0;
         r_s2_item  <= 1'b0;
         r_s2_lbl   <= 1'b0;
         r_s2_idx   <= 3'd0;
      end else if (pix_en) begin
         r_rom_addr <= r_s1_lbl ? w_addr : 14'd0;
         r_s2_act   <= r_s1_act;
         r_s2_item  <= r_s1_item;
         r_s2_lbl   <= r_s1_lbl;
         r_s2_idx   <= r_s1_idx;
      end
   end

   // S3 combinational: colour priority, using the ROM bit that answered S2.
   always_comb begin
      if (!r_s2_act) begin
         w_pix_nxt = COL_BLACK;
      end else if (r_s2_lbl && rom_data) begin
         w_pix_nxt = COL_TEXT;
      end else if (r_s2_item && (r_state == ST_PRESS) && (r_s2_idx == r_pressed)) begin
         w_pix_nxt = COL_PRESS;
      end else if (r_s2_item && (r_state != ST_IDLE) && (r_s2_idx == r_focus)) begin
         w_pix_nxt = COL_FOCUS;
      end else if (r_s2_item) begin
         w_pix_nxt = COL_ITEM;
      end else begin
         w_pix_nxt = COL_BLACK;
      end
   end

   // S3 registers: output pixel and aligned active flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pixel      <= COL_BLACK;
         r_out_active <= 1'b0;
      end else if (pix_en) begin
         r_pixel      <= w_pix_nxt;
         r_out_active <= r_s2_act;
      end
   end

   // Mouse hover, hover-change and button edge detection.
   always_comb begin
      w_hov       = item_lookup(mouse_x, mouse_y);
      w_hov_v     = w_hov[3];
      w_hov_idx   = w_hov[2:0];
      w_hov_new   = w_hov_v && (!r_hov_prev_v || (r_hov_prev_idx != w_hov_idx));
      w_btn_rise  = mouse_btn && !r_btn_q;
      w_btn_fall  = !mouse_btn && r_btn_q;
      w_focus_inc = (r_focus == LAST_IDX) ? 3'd0 : (r_focus + 3'd1);
      w_focus_dec = (r_focus == 3'd0) ? LAST_IDX : (r_focus - 3'd1);
   end

   // Selection FSM next state: focus moves, press tracking, confirmation.
   always_comb begin
      w_state_nxt   = r_state;
      w_focus_nxt   = r_focus;
      w_pressed_nxt = r_pressed;
      w_sel_idx_nxt = r_sel_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_hov_v) begin
               w_state_nxt = ST_HOVER;
               w_focus_nxt = w_hov_idx;
            end else if (key_up || key_down) begin
               w_state_nxt = ST_HOVER;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HOVER: begin
            // Mouse focus wins over a key pulse in the same cycle.
            if (w_hov_new) begin
               w_focus_nxt = w_hov_idx;
            end else if (key_down && !key_up) begin
               w_focus_nxt = w_focus_inc;
            end else if (key_up && !key_down) begin
               w_focus_nxt = w_focus_dec;
            end else begin
               w_focus_nxt = r_focus;
            end
            if (w_btn_rise && w_hov_v) begin
               w_state_nxt   = ST_PRESS;
               w_pressed_nxt = w_hov_idx;
            end else if (key_enter) begin
               w_state_nxt   = ST_HOLD;
               w_sel_idx_nxt = r_focus;
            end else begin
               w_state_nxt   = ST_HOVER;
            end
         end
         ST_PRESS: begin
            if (w_btn_fall) begin
               if (w_hov_v && (w_hov_idx == r_pressed)) begin
                  w_state_nxt   = ST_HOLD;
                  w_sel_idx_nxt = r_pressed;
               end else begin
                  w_state_nxt   = ST_HOVER;
               end
            end else begin
               w_state_nxt = ST_PRESS;
            end
         end
         ST_HOLD: begin
            if (sel_ready) begin
               w_state_nxt = ST_HOVER;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_focus_nxt   = 3'd0;
            w_pressed_nxt = 3'd0;
            w_sel_idx_nxt = 3'd0;
         end
      endcase
   end

   // Selection FSM state, handshake output and mouse history registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_focus        <= 3'd0;
         r_pressed      <= 3'd0;
         r_sel_idx      <= 3'd0;
         r_sel_valid    <= 1'b0;
         r_btn_q        <= 1'b0;
         r_hov_prev_v   <= 1'b0;
         r_hov_prev_idx <= 3'd0;
      end else begin
         r_state        <= w_state_nxt;
         r_focus        <= w_focus_nxt;
         r_pressed      <= w_pressed_nxt;
         r_sel_idx      <= w_sel_idx_nxt;
         r_sel_valid    <= (w_state_nxt == ST_HOLD);
         r_btn_q        <= mouse_btn;
         r_hov_prev_v   <= w_hov_v;
         r_hov_prev_idx <= w_hov_idx;
      end
   end

   assign rom_addr   = r_rom_addr;
   assign pixel      = r_pixel;
   assign out_active = r_out_active;
   assign sel_valid  = r_sel_valid;
   assign sel_idx    = r_sel_idx;
   assign focus_idx  = r_focus;

endmodule

// File: tb/tb_render_menu_n.sv
// Directed bench for render_menu_n: a table of render vectors plus
// hand-written sequences for latency, keyboard, mouse, handshake and reset.
module tb_render_menu_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        in_active;
   logic [9:0]  mouse_x;
   logic [9:0]  mouse_y;
   logic        mouse_btn;
   logic        key_up;
   logic        key_down;
   logic        key_enter;
   logic [13:0] rom_addr;
   logic        rom_data;
   logic [11:0] pixel;
   logic        out_active;
   logic        sel_valid;
   logic [2:0]  sel_idx;
   logic        sel_ready;
   logic [2:0]  focus_idx;
   logic        rom_one;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        act;
      logic        rom1;
      logic [11:0] pix;
      logic [13:0] addr;
   } vec_t;

   vec_t vecs[18];

   render_menu_n dut (
      .clk        (clk),
      .rst        (rst),
      .pix_en     (pix_en),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .in_active  (in_active),
      .mouse_x    (mouse_x),
      .mouse_y    (mouse_y),
      .mouse_btn  (mouse_btn),
      .key_up     (key_up),
      .key_down   (key_down),
      .key_enter  (key_enter),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .pixel      (pixel),
      .out_active (out_active),
      .sel_valid  (sel_valid),
      .sel_idx    (sel_idx),
      .sel_ready  (sel_ready),
      .focus_idx  (focus_idx)
   );

   always #5 clk = ~clk;

   // Synchronous glyph ROM stand-in: answers one clk after the address.
   always @(posedge clk) rom_data <= rom_one;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      repeat (3) tick();
   endtask

   task automatic render(input logic [9:0] h, input logic [9:0] v, input logic act, input logic r1);
      h_cnt = h; v_cnt = v; in_active = act; rom_one = r1;
      repeat (3) strobe();
   endtask

   task automatic set_mouse(input logic [9:0] x, input logic [9:0] y);
      mouse_x = x; mouse_y = y;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pixel"},  32'(pixel),      32'h000);
      check({tag, "_oact"},   32'(out_active), 32'd0);
      check({tag, "_addr"},   32'(rom_addr),   32'd0);
      check({tag, "_valid"},  32'(sel_valid),  32'd0);
      check({tag, "_selidx"}, 32'(sel_idx),    32'd0);
      check({tag, "_focus"},  32'(focus_idx),  32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{10'd160, 10'd80,  1'b1, 1'b0, 12'h521, 14'd0};
      vecs[1]  = '{10'd159, 10'd80,  1'b1, 1'b0, 12'h000, 14'd0};
      vecs[2]  = '{10'd160, 10'd140, 1'b1, 1'b0, 12'h000, 14'd0};
      vecs[3]  = '{10'd479, 10'd139, 1'b1, 1'b0, 12'h521, 14'd0};
      vecs[4]  = '{10'd480, 10'd100, 1'b1, 1'b0, 12'h000, 14'd0};
      vecs[5]  = '{10'd160, 10'd79,  1'b1, 1'b0, 12'h000, 14'd0};
      vecs[6]  = '{10'd241, 10'd91,  1'b1, 1'b1, 12'hfff, 14'd0};
      vecs[7]  = '{10'd243, 10'd213, 1'b1, 1'b1, 12'hfff, 14'd1261};
      vecs[8]  = '{10'd243, 10'd213, 1'b1, 1'b0, 12'h521, 14'd1261};
      vecs[9]  = '{10'd160, 10'd80,  1'b0, 1'b1, 12'h000, 14'd0};
      vecs[10] = '{10'd239, 10'd100, 1'b1, 1'b1, 12'h521, 14'd0};
      vecs[11] = '{10'd359, 10'd249, 1'b1, 1'b1, 12'hfff, 14'd2399};
      vecs[12] = '{10'd360, 10'd249, 1'b1, 1'b1, 12'h521, 14'd0};
      vecs[13] = '{10'd300, 10'd250, 1'b1, 1'b1, 12'h521, 14'd0};
      vecs[14] = '{10'd160, 10'd320, 1'b1, 1'b0, 12'h521, 14'd0};
      vecs[15] = '{10'd200, 10'd380, 1'b1, 1'b0, 12'h000, 14'd0};
      vecs[16] = '{10'd240, 10'd330, 1'b1, 1'b1, 12'hfff, 14'd2400};
      vecs[17] = '{10'd241, 10'd89,  1'b1, 1'b1, 12'h521, 14'd0};

      rst = 1'b0; pix_en = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0; in_active = 1'b0;
      mouse_x = 10'd0; mouse_y = 10'd0; mouse_btn = 1'b0;
      key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; sel_ready = 1'b0; rom_one = 1'b0;
      repeat (3) tick();
      check_reset_outputs("por");
      rst = 1'b1;
      tick();

      // Render table, FSM idle so no focus colour.
      for (int i = 0; i < 18; i++) begin
         render(vecs[i].h, vecs[i].v, vecs[i].act, vecs[i].rom1);
         check($sformatf("vec%0d_pixel", i), 32'(pixel),      32'(vecs[i].pix));
         check($sformatf("vec%0d_addr", i),  32'(rom_addr),   32'(vecs[i].addr));
         check($sformatf("vec%0d_oact", i),  32'(out_active), 32'(vecs[i].act));
      end

      // Latency: new pixel reaches the output on the third strobe only.
      render(10'd160, 10'd80, 1'b1, 1'b0);
      h_cnt = 10'd159;
      strobe(); check("lat_s1", 32'(pixel), 32'h521);
      strobe(); check("lat_s2", 32'(pixel), 32'h521);
      strobe(); check("lat_s3", 32'(pixel), 32'h000);

      // ROM address moves on the second strobe and holds in between.
      render(10'd243, 10'd213, 1'b1, 1'b0);
      h_cnt = 10'd241; v_cnt = 10'd91;
      strobe(); check("addr_s1", 32'(rom_addr), 32'd1261);
      repeat (5) tick(); check("addr_hold", 32'(rom_addr), 32'd1261);
      strobe(); check("addr_s2", 32'(rom_addr), 32'd0);

      // Keyboard focus with wrap.
      key_up = 1'b1; tick(); key_up = 1'b0; check("key_up1", 32'(focus_idx), 32'd0);
      key_up = 1'b1; tick(); key_up = 1'b0; check("key_up2", 32'(focus_idx), 32'd2);
      key_down = 1'b1; tick(); key_down = 1'b0; check("key_dn1", 32'(focus_idx), 32'd0);
      key_down = 1'b1; tick(); key_down = 1'b0; check("key_dn2", 32'(focus_idx), 32'd1);
      key_up = 1'b1; key_down = 1'b1; tick(); key_up = 1'b0; key_down = 1'b0;
      check("key_both", 32'(focus_idx), 32'd1);
      render(10'd200, 10'd220, 1'b1, 1'b0); check("focus_pix", 32'(pixel), 32'h632);
      render(10'd160, 10'd80,  1'b1, 1'b0); check("other_pix", 32'(pixel), 32'h521);
      key_down = 1'b1; tick(); key_down = 1'b0; check("key_dn3", 32'(focus_idx), 32'd2);

      // Mouse click on item 1.
      set_mouse(10'd200, 10'd220); tick(); check("mouse_focus", 32'(focus_idx), 32'd1);
      mouse_btn = 1'b1; tick();
      render(10'd200, 10'd220, 1'b1, 1'b0); check("press_pix", 32'(pixel), 32'h743);
      check("press_novalid", 32'(sel_valid), 32'd0);
      mouse_btn = 1'b0; tick();
      check("click_valid", 32'(sel_valid), 32'd1);
      check("click_idx",   32'(sel_idx),   32'd1);

      // Handshake: inputs ignored while holding.
      for (int i = 0; i < 5; i++) begin
         key_enter = (i == 2); key_down = (i == 3); mouse_btn = (i == 1);
         tick();
         check($sformatf("hold%0d_valid", i), 32'(sel_valid), 32'd1);
         check($sformatf("hold%0d_idx", i),   32'(sel_idx),   32'd1);
      end
      key_enter = 1'b0; key_down = 1'b0; mouse_btn = 1'b0;
      check("hold_focus", 32'(focus_idx), 32'd1);
      sel_ready = 1'b1; tick(); sel_ready = 1'b0;
      check("ready_drop", 32'(sel_valid), 32'd0);
      tick(); check("ready_stay", 32'(sel_valid), 32'd0);

      // Drag release off the item gives no selection.
      mouse_btn = 1'b1; tick();
      set_mouse(10'd200, 10'd300); tick();
      mouse_btn = 1'b0; tick();
      for (int i = 0; i < 3; i++) begin
         tick(); check($sformatf("drag%0d_valid", i), 32'(sel_valid), 32'd0);
      end
      render(10'd200, 10'd220, 1'b1, 1'b0); check("drag_pix", 32'(pixel), 32'h632);

      // Press with no hover is ignored: enter still confirms from HOVER.
      mouse_btn = 1'b1; tick();
      key_enter = 1'b1; tick(); key_enter = 1'b0;
      check("nohov_valid", 32'(sel_valid), 32'd1);
      check("nohov_idx",   32'(sel_idx),   32'd1);
      sel_ready = 1'b1; tick(); sel_ready = 1'b0; mouse_btn = 1'b0;
      check("nohov_done", 32'(sel_valid), 32'd0);
      tick();

      // Reset in the middle of a press.
      set_mouse(10'd200, 10'd220); tick();
      mouse_btn = 1'b1; tick();
      render(10'd243, 10'd213, 1'b1, 1'b0);
      check("pre_rst_pix",  32'(pixel),    32'h743);
      check("pre_rst_addr", 32'(rom_addr), 32'd1261);
      rst = 1'b0; #1;
      check_reset_outputs("rst");
      repeat (2) tick();
      rst = 1'b1;
      tick(); check("resume_focus", 32'(focus_idx), 32'd1);
      mouse_btn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); check($sformatf("post_rst%0d_valid", i), 32'(sel_valid), 32'd0);
      end
      render(10'd200, 10'd220, 1'b1, 1'b0); check("post_rst_pix", 32'(pixel), 32'h632);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/render_menu_n.md
RENDER_MENU_N -- requirements
Module: render_menu_n

Interface
REQ-001 Parameters SHALL be: N_ITEMS, 3, number of buttons (1..8); X0, 160, button left edge; Y0, 80, first button top edge; BTN_W, 320, button width; BTN_H, 60, button height; PITCH, 120, vertical distance between button tops; LBL_W, 60, label glyph columns; LBL_H, 20, label glyph rows; LBL_S, 2, label scale; LBL_DX, 80, label offset inside button; LBL_DY, 10, label offset inside button.
REQ-002 clk input 1: the only clock. All logic SHALL be on its rising edge.
REQ-003 rst input 1: asynchronous, active-low reset.
REQ-004 pix_en input 1: one-cycle pixel strobe. The render pipeline SHALL advance only on pix_en.
REQ-005 h_cnt and v_cnt inputs 10 each: coordinates of the current pixel. They SHALL be valid when pix_en is high.
REQ-006 in_active input 1: the pixel is inside the visible area.
REQ-007 mouse_x and mouse_y inputs 10 each: cursor position.
REQ-008 mouse_btn input 1: left button level.
REQ-009 key_up, key_down and key_enter inputs 1 each: single-cycle pulses.
REQ-010 rom_addr output 14: glyph ROM address. The external synchronous ROM SHALL return data 1 clk after the address.
REQ-011 rom_data input 1: glyph bit, 1 means text.
REQ-012 pixel output 12: RGB444 value.
REQ-013 out_active output 1: in_active delayed to align with pixel.
REQ-014 sel_valid output 1: a confirmed selection is pending.
REQ-015 sel_idx output 3: the confirmed item index.
REQ-016 sel_ready input 1: the consumer accepts the selection.
REQ-017 focus_idx output 3: the current focus index.

Function
REQ-018 Item i SHALL occupy x in [X0, X0+BTN_W) and y in [Y0+i*PITCH, Y0+i*PITCH+BTN_H). Intervals SHALL be half-open.
REQ-019 Label i SHALL occupy x in [X0+LBL_DX, X0+LBL_DX+LBL_W*LBL_S) and y in [top_i+LBL_DY, top_i+LBL_DY+LBL_H*LBL_S), where top_i is the top edge of item i.
REQ-020 Label address SHALL be i*LBL_W*LBL_H + row*LBL_W + col, where row and col are the pixel offset divided by LBL_S. Outside any label the address SHALL be 0.
REQ-021 Pipeline stage S1 SHALL compute item hit, label hit and the item index.
REQ-022 Pipeline stage S2 SHALL register rom_addr and the S1 flags.
REQ-023 Pipeline stage S3 SHALL register pixel and out_active.
REQ-024 Each stage SHALL advance on pix_en, giving a latency of exactly 3 pix_en strobes from the inputs to pixel.
REQ-025 rom_addr SHALL be held between strobes.
REQ-026 The pixel colour SHALL be chosen in priority order: in_active=0 gives 12'h000; label hit with rom_data=1 gives 12'hfff; pressed item gives 12'h743; focused item gives 12'h632; any other item gives 12'h521; everything else gives 12'h000.
REQ-027 The hover index SHALL be the item under the mouse, or none.
REQ-028 The selection FSM SHALL have states IDLE, HOVER, PRESS and HOLD.
REQ-029 In IDLE with hover present, the FSM SHALL go to HOVER and set focus to the hover index.
REQ-030 In IDLE, a key_up or key_down pulse SHALL go to HOVER and keep the current focus.
REQ-031 In HOVER, key_down SHALL set focus to (focus+1) mod N_ITEMS.
REQ-032 In HOVER, key_up SHALL set focus to (focus-1) mod N_ITEMS, so 0 wraps to N_ITEMS-1.
REQ-033 Simultaneous key_up and key_down SHALL leave focus unchanged.
REQ-034 In HOVER, a change in the hover index to a valid item SHALL set focus to that item. Mouse focus SHALL take priority over a key pulse in the same cycle.
REQ-035 In HOVER, key_enter SHALL go to HOLD with sel_idx set to focus.
REQ-036 In HOVER, a rising edge of mouse_btn while hover is valid SHALL go to PRESS and latch the pressed index. A mouse_btn edge with no hover SHALL be ignored.
REQ-037 In PRESS, keys SHALL be ignored.
REQ-038 In PRESS, a falling edge of mouse_btn with hover equal to the pressed index SHALL go to HOLD with sel_idx set to the pressed index.
REQ-039 In PRESS, a falling edge of mouse_btn anywhere else SHALL go to HOVER with no selection.
REQ-040 In HOLD, sel_valid SHALL be 1 and sel_idx SHALL be stable.
REQ-041 In HOLD, the FSM SHALL leave only on the first cycle with sel_ready=1, returning to HOVER with sel_valid low the next cycle.
REQ-042 In HOLD, all mouse and key inputs SHALL be ignored.
REQ-043 The pressed colour SHALL apply only in PRESS, to the latched pressed index.
REQ-044 The focus colour SHALL apply in HOVER, PRESS and HOLD. In IDLE, no item SHALL be focused.
REQ-045 Arithmetic for coordinate offsets SHALL be unsigned 10-bit. Offsets SHALL be computed only after a range hit, so underflow never reaches rom_addr.
REQ-046 The mouse_btn edge register SHALL sample on every clk, independent of pix_en.

Reset
REQ-047 While rst=0, the FSM SHALL be in IDLE with focus_idx=0, sel_idx=0, sel_valid=0, rom_addr=0, pixel=12'h000, out_active=0, the pipeline flags cleared and the mouse_btn history cleared.
REQ-048 Reset asserted in any state, including PRESS or HOLD, SHALL discard a pending selection with no sel_valid pulse.
REQ-049 Operation SHALL resume from IDLE on the first clk after rst rises.

Verification
REQ-050 Render check. Stimulus: defaults, mouse away, h=160, v=80, in_active=1. Response: 3 pix_en later pixel=12'h521. For h=159: 12'h000. For v=140: 12'h000.
REQ-051 Label check. Stimulus: pixel (241,91) with rom_data forced to 1. Response: rom_addr=0 one strobe after, then pixel=12'hfff. Stimulus: pixel (243,213). Response: rom_addr=1200+1*60+1=1261.
REQ-052 Keyboard wrap check. Stimulus: from IDLE, key_up, key_up. Response: focus 0 then 2. Stimulus: key_down. Response: focus 0. Stimulus: key_up and key_down together. Response: focus unchanged.
REQ-053 Mouse click check. Stimulus: mouse at (200,220), press, release. Response: PRESS with pixel 12'h743 on item 1, then sel_valid=1, sel_idx=1. Stimulus: drag release at (200,300). Response: no sel_valid.
REQ-054 Handshake check. Stimulus: HOLD with sel_ready low for 5 cycles and key_enter pulsed. Response: sel_valid stays 1 and sel_idx is unchanged. Stimulus: sel_ready=1. Response: sel_valid=0 the next cycle.
REQ-055 Reset check. Stimulus: rst low mid-PRESS. Response: all outputs at reset values immediately, and no selection after rst rises.
